alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational execute-stage ALU between two requesters: requester 0 is the core pipeline and requester 1 is the auxiliary sequencer, such as the branch/address helper. A round-robin arbiter admits at most one operation per cycle and drives the shared ALU's operand and control inputs. It registers the result into a per-requester response slot. Each slot is held until its owner accepts it with a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  operation request
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_ctrl / req1_ctrl  in  4  ALU operation code (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001)
- req0_op1 / req1_op1  in  DATA_WIDTH  first operand
- req0_op2 / req1_op2  in  DATA_WIDTH  second operand
- rsp0_valid / rsp1_valid  out  1  response slot holds a result
- rsp0_ready / rsp1_ready  in  1  owner consumes response
- rsp0_data / rsp1_data  out  DATA_WIDTH  registered ALU result
- rsp0_eq / rsp1_eq  out  1  registered operand-equality flag
- alu_op1  out  DATA_WIDTH  shared ALU first operand
- alu_op2  out  DATA_WIDTH  shared ALU second operand; the ALU's immediate select is tied to register-operand
- alu_ctrl  out  4  shared ALU control
- alu_out  in  DATA_WIDTH  shared ALU result (combinational)
- alu_eq  in  1  shared ALU equality flag
- grant_id  out  1  winner this cycle; meaningful only when a grant occurs

## Operation
- Slot free for requester i: free_i = !rspi_valid || rspi_ready.
- Eligible: elig_i = reqi_valid && free_i && !rst.
- State: a 1-bit priority pointer prio. At reset prio = 0, so requester 0 is preferred.
- Grant rule:
  - If both requesters are eligible, requester prio wins.
  - If only one is eligible, it wins regardless of prio (work-conserving).
  - If none is eligible, there is no grant.
- On a grant to i, prio becomes 1-i, so the other requester is preferred next.
- With no grant, prio is unchanged.
- reqi_ready = granted to i. At most one ready is high per cycle, and never while rst is high.
- ALU drive: when there is a grant, alu_op1, alu_op2 and alu_ctrl come from the winner. With no grant they are all zero (ctrl 0000).
- Capture: at the edge ending a grant cycle, rsp_data_i <= alu_out, rsp_eq_i <= alu_eq, rspi_valid <= 1.
- Slot release: if rspi_ready && rspi_valid and there is no new grant to i, rspi_valid <= 0. Data and eq hold their last values.
- Simultaneous consume and grant to the same i: valid stays 1 and data/eq are replaced with the new result, giving back-to-back throughput.
- Requesters must hold ctrl and operands stable while valid and not ready. The arbiter does not latch requests.
- Codes 1010-1111 are passed through unchanged; the ALU returns 0 for them.
- Starvation bound: an eligible requester is granted within 2 cycles.

## Timing
- Reset, synchronous: on a clk edge with rst=1, rsp0_valid = rsp1_valid = 0, rsp*_data = 0, rsp*_eq = 0 and prio = 0.
- While rst=1, req*_ready = 0 and alu_* = 0.
- Latency: accept in cycle N, so rspi_valid = 1 and the data are visible in cycle N+1.
- Throughput: one operation per cycle in total; each requester gets one per cycle when alone.
- Backpressure: while rspi_valid=1 and rspi_ready=0, reqi_ready = 0. The other requester is unaffected.
- Reset mid-operation: in-flight results are discarded. Requests held across reset are re-arbitrated from prio = 0 in the first cycle after rst falls.
- Grant and ALU drive are combinational from the request inputs, the rsp_ready inputs and the state. There is no combinational path from alu_out to any ready signal.

## Test plan
- Reset then single op:
  - Stimulus: rst 2 cycles, then req0 ADD 5+7.
  - Required: req0_ready=1 in cycle 0; rsp0_valid=1 with rsp0_data=12 and rsp0_eq=0 in cycle 1; rsp1_valid stays 0.
- Contention round-robin:
  - Stimulus: both requesters valid continuously; req0 SUB 10-3, req1 SLT -1<1; both rsp_ready=1.
  - Required: grants alternate 0,1,0,1 from reset. rsp0_data=7. rsp1_data=1.
- Backpressure:
  - Stimulus: rsp0_ready=0 after the first req0 result (XOR 0xFF^0x0F=0xF0); req0 keeps requesting.
  - Required: req0_ready=0 while blocked and rsp0_data holds 0xF0. req1 is granted every cycle meanwhile.
- Back-to-back same requester:
  - Stimulus: req0 alone, rsp0_ready=1, ops SLL 1<<4 then SRA 0x80000000>>>4.
  - Required: rsp0_valid continuously 1; data 0x10 then 0xF8000000 on consecutive cycles.
- Equality flag:
  - Stimulus: req1 SUB 9-9.
  - Required: rsp1_data=0 and rsp1_eq=1.
- Reset mid-operation:
  - Stimulus: assert rst while rsp0_valid=1 and both requests pending.
  - Required: all outputs reach their reset values next cycle. After release, requester 0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational execute-stage ALU between the core pipeline
// (requester 0) and the auxiliary sequencer (requester 1). A 1-bit
// round-robin pointer picks at most one operation per cycle. That operation
// drives the shared ALU, and the ALU result is captured into the winner's
// response slot. Each slot is held until its owner takes it with
// rspN_ready.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/_ready         request handshake (ready is combinational)
//   reqN_ctrl/_op1/_op2       ALU operation code and operands
//   rspN_valid/_ready         response slot handshake
//   rspN_data/_eq             registered ALU result and equality flag
//   alu_op1/_op2/_ctrl        shared ALU drive (zero when there is no grant)
//   alu_out/_eq               shared ALU result (combinational)
//   grant_id                  winner this cycle (valid only with a grant)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp0_eq,

    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rsp1_eq,

    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_eq,

    output logic                  grant_id
);

    localparam int unsigned CTRL_W = 4;

    // Priority pointer values: which requester wins a tie.
    localparam logic [0:0] PRIO_REQ0 = 1'b0;
    localparam logic [0:0] PRIO_REQ1 = 1'b1;

    logic                  prio_q, prio_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
    logic                  rsp0_eq_q, rsp0_eq_d;
    logic                  rsp1_eq_q, rsp1_eq_d;

    logic free0, free1;
    logic elig0, elig1;
    logic gnt0, gnt1;

    // Eligibility and round-robin grant. A slot counts as free when it is
    // being drained this cycle. This allows back-to-back ops per requester.
    always_comb begin : arb_comb
        free0 = !rsp0_valid_q || rsp0_ready;
        free1 = !rsp1_valid_q || rsp1_ready;
        elig0 = req0_valid && free0 && !rst;
        elig1 = req1_valid && free1 && !rst;
        gnt0  = elig0 && (!elig1 || (prio_q == PRIO_REQ0));
        gnt1  = elig1 && (!elig0 || (prio_q == PRIO_REQ1));
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign grant_id   = gnt1;

    // Shared ALU drive: winner's operands, all-zero when idle.
    always_comb begin : alu_drive
        alu_op1  = '0;
        alu_op2  = '0;
        alu_ctrl = CTRL_W'(0);
        if (gnt0) begin
            alu_op1  = req0_op1;
            alu_op2  = req0_op2;
            alu_ctrl = req0_ctrl;
        end else if (gnt1) begin
            alu_op1  = req1_op1;
            alu_op2  = req1_op2;
            alu_ctrl = req1_ctrl;
        end
    end

    // Next state: pointer rotation, result capture, slot release.
    always_comb begin : next_state
        prio_d       = prio_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        rsp0_eq_d    = rsp0_eq_q;
        rsp1_eq_d    = rsp1_eq_q;

        if (gnt0) begin
            prio_d = PRIO_REQ1;
        end else if (gnt1) begin
            prio_d = PRIO_REQ0;
        end

        if (gnt0) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_out;
            rsp0_eq_d    = alu_eq;
        end else if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        if (gnt1) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_out;
            rsp1_eq_d    = alu_eq;
        end else if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    // State registers. Reset clears the slots and discards in-flight results.
    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            prio_q       <= PRIO_REQ0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            rsp0_eq_q    <= 1'b0;
            rsp1_eq_q    <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp0_eq_q    <= rsp0_eq_d;
            rsp1_eq_q    <= rsp1_eq_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp0_eq    = rsp0_eq_q;
    assign rsp1_eq    = rsp1_eq_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Bench for alu_arbiter. It provides a behavioural shared ALU and runs one
// task per scenario. Expected responses are pushed into per-requester
// queues when a grant is seen. They are popped and compared when the slot
// presents its result.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          eq;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [3:0]    req0_ctrl, req1_ctrl;
    logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready, rsp1_ready;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          rsp0_eq, rsp1_eq;
    logic [DW-1:0] alu_op1, alu_op2, alu_out;
    logic [3:0]    alu_ctrl;
    logic          alu_eq;
    logic          grant_id;

    int n_pass  = 0;
    int n_total = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_eq    (rsp0_eq),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_eq    (rsp1_eq),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_eq     (alu_eq),
        .grant_id   (grant_id)
    );

    // Behavioural model of the shared combinational ALU.
    function automatic logic [DW-1:0] alu_model(input logic [3:0] c,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return a << b[4:0];
            4'b0110: return a >> b[4:0];
            4'b0111: return DW'($signed(a) >>> b[4:0]);
            4'b1000: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            4'b1001: return (a < b) ? DW'(1) : DW'(0);
            default: return DW'(0);
        endcase
    endfunction

    always_comb begin
        alu_out = alu_model(alu_ctrl, alu_op1, alu_op2);
        alu_eq  = (alu_op1 == alu_op2);
    end

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_ctrl = 4'd0; req0_op1 = '0; req0_op2 = '0;
        req1_valid = 1'b0; req1_ctrl = 4'd0; req1_op1 = '0; req1_op2 = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with rst low.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        req0_valid = 1'b1; req0_ctrl = 4'd0; req0_op1 = 32'd3; req0_op2 = 32'd4;
        req1_valid = 1'b1; req1_ctrl = 4'd1; req1_op1 = 32'd8; req1_op2 = 32'd2;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (rsp0_valid !== 1'b0) $display("FAIL reset.rsp0_valid got %b exp 0", rsp0_valid); else n_pass++;
        n_total++; if (rsp1_valid !== 1'b0) $display("FAIL reset.rsp1_valid got %b exp 0", rsp1_valid); else n_pass++;
        n_total++; if (rsp0_data !== 32'd0) $display("FAIL reset.rsp0_data got %h exp 0", rsp0_data); else n_pass++;
        n_total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL reset.ready got %b%b exp 00", req0_ready, req1_ready); else n_pass++;
        n_total++; if (alu_op1 !== 32'd0 || alu_op2 !== 32'd0 || alu_ctrl !== 4'd0)
            $display("FAIL reset.alu got %h %h %h exp 0", alu_op1, alu_op2, alu_ctrl); else n_pass++;
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single();
        exp_t e;
        req0_valid = 1'b1; req0_ctrl = 4'b0000; req0_op1 = 32'd5; req0_op2 = 32'd7;
        #1;
        n_total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL single.ready got %b%b exp 10", req0_ready, req1_ready); else n_pass++;
        n_total++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || alu_ctrl !== 4'd0 || grant_id !== 1'b0)
            $display("FAIL single.alu_drive got %h %h %h g%b", alu_op1, alu_op2, alu_ctrl, grant_id); else n_pass++;
        if (req0_ready === 1'b1) q0.push_back('{d: 32'd12, eq: 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_total++; if (rsp0_valid !== 1'b1) $display("FAIL single.rsp0_valid got %b exp 1", rsp0_valid); else n_pass++;
        n_total++;
        if (q0.size() == 0) $display("FAIL single.sb0 no expected entry, got %h", rsp0_data);
        else begin
            e = q0.pop_front();
            if (rsp0_data !== e.d || rsp0_eq !== e.eq)
                $display("FAIL single.rsp0 got %h/%b exp %h/%b", rsp0_data, rsp0_eq, e.d, e.eq);
            else n_pass++;
        end
        n_total++; if (rsp1_valid !== 1'b0) $display("FAIL single.rsp1_valid got %b exp 0", rsp1_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp0_valid !== 1'b0) $display("FAIL single.release got %b exp 0", rsp0_valid); else n_pass++;
    endtask

    task automatic test_contention();
        exp_t e;
        logic g;
        do_reset();
        req0_valid = 1'b1; req0_ctrl = 4'b0001; req0_op1 = 32'd10;         req0_op2 = 32'd3;
        req1_valid = 1'b1; req1_ctrl = 4'b1000; req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'd1;
        for (int k = 0; k < 4; k++) begin
            g = 1'(k % 2);
            #1;
            n_total++;
            if (req0_ready !== !g || req1_ready !== g || grant_id !== g)
                $display("FAIL contention.grant%0d got %b%b id%b exp winner %0d", k, req0_ready, req1_ready, grant_id, g);
            else n_pass++;
            if (req0_ready === 1'b1) q0.push_back('{d: 32'd7, eq: 1'b0});
            if (req1_ready === 1'b1) q1.push_back('{d: 32'd1, eq: 1'b0});
            @(posedge clk); #1;
            n_total++;
            if (g == 1'b0) begin
                if (q0.size() == 0) $display("FAIL contention.sb0 no expected entry, got %h", rsp0_data);
                else begin
                    e = q0.pop_front();
                    if (rsp0_valid !== 1'b1 || rsp0_data !== e.d)
                        $display("FAIL contention.rsp0 got v%b %h exp %h", rsp0_valid, rsp0_data, e.d);
                    else n_pass++;
                end
            end else begin
                if (q1.size() == 0) $display("FAIL contention.sb1 no expected entry, got %h", rsp1_data);
                else begin
                    e = q1.pop_front();
                    if (rsp1_valid !== 1'b1 || rsp1_data !== e.d)
                        $display("FAIL contention.rsp1 got v%b %h exp %h", rsp1_valid, rsp1_data, e.d);
                    else n_pass++;
                end
            end
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_ctrl = 4'b0100; req0_op1 = 32'hFF; req0_op2 = 32'h0F;
        req1_valid = 1'b1; req1_ctrl = 4'b0000; req1_op1 = 32'd1;  req1_op2 = 32'd2;
        #1;
        n_total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL bp.first_grant got %b%b exp 10", req0_ready, req1_ready); else n_pass++;
        if (req0_ready === 1'b1) q0.push_back('{d: 32'hF0, eq: 1'b0});
        @(posedge clk); #1;
        n_total++;
        if (q0.size() == 0) $display("FAIL bp.sb0 no expected entry, got %h", rsp0_data);
        else begin
            e = q0.pop_front();
            if (rsp0_valid !== 1'b1 || rsp0_data !== e.d)
                $display("FAIL bp.rsp0 got v%b %h exp %h", rsp0_valid, rsp0_data, e.d);
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1)
                $display("FAIL bp.blocked%0d got %b%b exp 01", k, req0_ready, req1_ready); else n_pass++;
            if (req1_ready === 1'b1) q1.push_back('{d: 32'd3, eq: 1'b0});
            @(posedge clk); #1;
            n_total++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'hF0)
                $display("FAIL bp.hold%0d got v%b %h exp 1 f0", k, rsp0_valid, rsp0_data); else n_pass++;
            n_total++;
            if (q1.size() == 0) $display("FAIL bp.sb1 no expected entry, got %h", rsp1_data);
            else begin
                e = q1.pop_front();
                if (rsp1_valid !== 1'b1 || rsp1_data !== e.d)
                    $display("FAIL bp.rsp1_%0d got v%b %h exp %h", k, rsp1_valid, rsp1_data, e.d);
                else n_pass++;
            end
        end
        rsp0_ready = 1'b1;
        #1;
        n_total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL bp.unblock got %b%b exp 10", req0_ready, req1_ready); else n_pass++;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        req0_valid = 1'b1; req0_ctrl = 4'b0101; req0_op1 = 32'd1; req0_op2 = 32'd4;
        #1;
        n_total++; if (req0_ready !== 1'b1) $display("FAIL b2b.ready0 got %b exp 1", req0_ready); else n_pass++;
        if (req0_ready === 1'b1) q0.push_back('{d: 32'h10, eq: 1'b0});
        @(posedge clk); #1;
        n_total++;
        if (q0.size() == 0) $display("FAIL b2b.sb0a no expected entry, got %h", rsp0_data);
        else begin
            e = q0.pop_front();
            if (rsp0_valid !== 1'b1 || rsp0_data !== e.d)
                $display("FAIL b2b.first got v%b %h exp %h", rsp0_valid, rsp0_data, e.d);
            else n_pass++;
        end
        req0_ctrl = 4'b0111; req0_op1 = 32'h8000_0000; req0_op2 = 32'd4;
        #1;
        n_total++; if (req0_ready !== 1'b1) $display("FAIL b2b.ready1 got %b exp 1", req0_ready); else n_pass++;
        if (req0_ready === 1'b1) q0.push_back('{d: 32'hF800_0000, eq: 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_total++;
        if (q0.size() == 0) $display("FAIL b2b.sb0b no expected entry, got %h", rsp0_data);
        else begin
            e = q0.pop_front();
            if (rsp0_valid !== 1'b1 || rsp0_data !== e.d)
                $display("FAIL b2b.second got v%b %h exp %h", rsp0_valid, rsp0_data, e.d);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_equality();
        exp_t e;
        do_reset();
        req1_valid = 1'b1; req1_ctrl = 4'b0001; req1_op1 = 32'd9; req1_op2 = 32'd9;
        #1;
        n_total++; if (req1_ready !== 1'b1 || grant_id !== 1'b1)
            $display("FAIL eq.grant got r%b id%b exp 1 1", req1_ready, grant_id); else n_pass++;
        if (req1_ready === 1'b1) q1.push_back('{d: 32'd0, eq: 1'b1});
        @(posedge clk); #1;
        n_total++;
        if (q1.size() == 0) $display("FAIL eq.sb1 no expected entry, got %h", rsp1_data);
        else begin
            e = q1.pop_front();
            if (rsp1_valid !== 1'b1 || rsp1_data !== e.d || rsp1_eq !== e.eq)
                $display("FAIL eq.rsp1 got v%b %h/%b exp %h/%b", rsp1_valid, rsp1_data, rsp1_eq, e.d, e.eq);
            else n_pass++;
        end
        // Reserved code: passed through to the ALU, which returns zero.
        req1_ctrl = 4'b1100; req1_op1 = 32'd3; req1_op2 = 32'd4;
        #1;
        n_total++; if (alu_ctrl !== 4'b1100) $display("FAIL eq.reserved_ctrl got %b exp 1100", alu_ctrl); else n_pass++;
        if (req1_ready === 1'b1) q1.push_back('{d: 32'd0, eq: 1'b0});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        n_total++;
        if (q1.size() == 0) $display("FAIL eq.sb1r no expected entry, got %h", rsp1_data);
        else begin
            e = q1.pop_front();
            if (rsp1_valid !== 1'b1 || rsp1_data !== e.d || rsp1_eq !== e.eq)
                $display("FAIL eq.reserved got v%b %h/%b exp %h/%b", rsp1_valid, rsp1_data, rsp1_eq, e.d, e.eq);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_ctrl = 4'b0000; req0_op1 = 32'd1; req0_op2 = 32'd1;
        #1;
        n_total++; if (req0_ready !== 1'b1) $display("FAIL rstmid.pre_grant got %b exp 1", req0_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd2 || rsp0_eq !== 1'b1)
            $display("FAIL rstmid.pre_rsp got v%b %h/%b exp 1 2/1", rsp0_valid, rsp0_data, rsp0_eq); else n_pass++;
        req1_valid = 1'b1; req1_ctrl = 4'b0000; req1_op1 = 32'd2; req1_op2 = 32'd2;
        rst = 1'b1;
        #1;
        n_total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_ctrl !== 4'd0 || alu_op1 !== 32'd0)
            $display("FAIL rstmid.in_reset got %b%b %h %h exp 00 0 0", req0_ready, req1_ready, alu_ctrl, alu_op1); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp0_valid !== 1'b0 || rsp0_data !== 32'd0 || rsp0_eq !== 1'b0 || rsp1_valid !== 1'b0)
            $display("FAIL rstmid.cleared got v%b %h/%b v1%b exp 0 0/0 0", rsp0_valid, rsp0_data, rsp0_eq, rsp1_valid); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL rstmid.first_after got %b%b exp 10", req0_ready, req1_ready); else n_pass++;
        q0.delete();
        q1.delete();
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after 200000 time units");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_equality();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
